// File: rtl/bnn_pkg.sv
// Shared constants, FSM encoding and helpers for the conv_mix stream controller.
// Every block of the controller imports this package.
package bnn_pkg;

    localparam int DATA_W  = 32;
    localparam int W_CNT   = 25;
    localparam int W_AW    = 5;
    localparam int IMG_PIX = 784;
    localparam int IMG_AW  = 10;
    localparam int RES_AW  = 10;
    localparam int N_OUT0  = 144;
    localparam int N_OUT1  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_PRE,
        ST_W_LOAD,
        ST_RUN,
        ST_FIN
    } ctrl_state_e;

    // Number of results a complete run must produce for the selected layer.
    function automatic logic [RES_AW:0] exp_results(input logic layer);
        return layer ? (RES_AW+1)'(N_OUT1) : (RES_AW+1)'(N_OUT0);
    endfunction

endpackage

// File: rtl/conv_stream_ctrl_if.sv
// conv_mix side handshake: start, weight load, pixel request/response and results.
// The master modport is the controller and the slave modport is the conv_mix engine.
interface conv_stream_ctrl_if #(
    parameter int DATA_W = bnn_pkg::DATA_W
);

    logic              start;
    logic              state;
    logic              weight_en;
    logic              weight;
    logic [DATA_W-1:0] din;
    logic              din_ready;
    logic              ovalid;
    logic              done;
    logic [DATA_W-1:0] dout;

    modport master (
        output start, state, weight_en, weight, din,
        input  din_ready, ovalid, done, dout
    );

    modport slave (
        input  start, state, weight_en, weight, din,
        output din_ready, ovalid, done, dout
    );

endinterface

// File: rtl/bnn_weight_loader.sv
// Prefetching weight-RAM sequencer: presents address 0 during W_PRE, then keeps the
// address one word ahead of the returning data while the binarized bits stream out.
module bnn_weight_loader
    import bnn_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            pre_i,
    input  logic            load_i,
    input  logic            w_sign_i,
    output logic [W_AW-1:0] w_addr_o,
    output logic            weight_en_o,
    output logic            weight_o,
    output logic            last_o
);

    localparam logic [W_AW-1:0] ADDR_LAST = W_AW'(W_CNT);

    logic [W_AW-1:0] w_addr_q, w_addr_d;

    // While loading, the address is always one past the word on the RAM output,
    // so the final word is on the bus when the address reads W_CNT.
    assign last_o = load_i && (w_addr_q == ADDR_LAST);

    always_comb begin
        // NOTE: every _d is given a default first so no path leaves it unassigned and no latch is inferred.
        w_addr_d = '0;
        if (pre_i) begin
            w_addr_d = W_AW'(1);
        end else if (load_i && !last_o) begin
            w_addr_d = w_addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
        if (!rstn) begin
            w_addr_q <= '0;
        end else begin
            w_addr_q <= w_addr_d;
        end
    end

    assign w_addr_o    = w_addr_q;
    assign weight_en_o = load_i;
    assign weight_o    = load_i & ~w_sign_i;

endmodule

// File: rtl/conv_stream_ctrl.sv
// On-chip driver for conv_mix: loads binarized weights, streams image pixels on request
// and captures every result into the result RAM, reporting count, finish and error.
module conv_stream_ctrl
    import bnn_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               go,
    input  logic               mode,
    output logic [W_AW-1:0]    w_addr,
    input  logic [DATA_W-1:0]  w_rdata,
    output logic [IMG_AW-1:0]  img_addr,
    input  logic [DATA_W-1:0]  img_rdata,
    conv_stream_ctrl_if.master cm,
    output logic               res_we,
    output logic [RES_AW-1:0]  res_addr,
    output logic [DATA_W-1:0]  res_wdata,
    output logic               busy,
    output logic               finish,
    output logic [RES_AW:0]    res_count,
    output logic               err
);

    localparam logic [IMG_AW:0] PIX_END   = (IMG_AW+1)'(IMG_PIX);
    localparam logic [RES_AW:0] RES_DEPTH = (RES_AW+1)'(1 << RES_AW);

    ctrl_state_e        state_q, state_d;
    logic               mode_q, mode_d;
    logic [IMG_AW:0]    pix_cnt_q, pix_cnt_d;
    logic               din_ok_q, din_ok_d;
    logic               res_we_q, res_we_d;
    logic [RES_AW-1:0]  res_addr_q, res_addr_d;
    logic [DATA_W-1:0]  res_wdata_q, res_wdata_d;
    logic [RES_AW:0]    res_count_q, res_count_d;
    logic               err_q, err_d;

    logic               load_last;
    logic               pix_avail;
    logic               unused_w_bits;

    // Only the sign bit of a weight word carries information.
    assign unused_w_bits = ^w_rdata[DATA_W-2:0];

    bnn_weight_loader u_weight_loader (
        .clk         (clk),
        .rstn        (rstn),
        .pre_i       (state_q == ST_W_PRE),
        .load_i      (state_q == ST_W_LOAD),
        .w_sign_i    (w_rdata[DATA_W-1]),
        .w_addr_o    (w_addr),
        .weight_en_o (cm.weight_en),
        .weight_o    (cm.weight),
        .last_o      (load_last)
    );

    assign pix_avail = (pix_cnt_q < PIX_END);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        pix_cnt_d   = pix_cnt_q;
        din_ok_d    = 1'b0;
        res_we_d    = 1'b0;
        res_addr_d  = res_addr_q;
        res_wdata_d = res_wdata_q;
        res_count_d = res_count_q;
        err_d       = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d     = ST_W_PRE;
                    mode_d      = mode;
                    pix_cnt_d   = '0;
                    res_count_d = '0;
                    err_d       = 1'b0;
                end
            end

            ST_W_PRE: state_d = ST_W_LOAD;

            ST_W_LOAD: begin
                if (load_last) state_d = ST_RUN;
            end

            ST_RUN: begin
                // The RAM reads img_addr at this edge; remember whether it was a real pixel.
                din_ok_d = pix_avail;
                if (cm.din_ready && pix_avail) pix_cnt_d = pix_cnt_q + 1'b1;

                // A simultaneous ovalid and done is one result, written once.
                if (cm.ovalid || cm.done) begin
                    if (res_count_q < RES_DEPTH) begin
                        res_we_d    = 1'b1;
                        res_addr_d  = res_count_q[RES_AW-1:0];
                        res_wdata_d = cm.dout;
                        res_count_d = res_count_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end

                if (cm.done) begin
                    state_d = ST_FIN;
                    if (res_count_d != exp_results(mode_q)) err_d = 1'b1;
                end
            end

            ST_FIN: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            pix_cnt_q   <= '0;
            din_ok_q    <= 1'b0;
            res_we_q    <= 1'b0;
            res_addr_q  <= '0;
            res_wdata_q <= '0;
            res_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pix_cnt_q   <= pix_cnt_d;
            din_ok_q    <= din_ok_d;
            res_we_q    <= res_we_d;
            res_addr_q  <= res_addr_d;
            res_wdata_q <= res_wdata_d;
            res_count_q <= res_count_d;
            err_q       <= err_d;
        end
    end

    assign busy     = (state_q == ST_W_PRE) || (state_q == ST_W_LOAD) || (state_q == ST_RUN);
    assign cm.start = busy;
    assign cm.state = mode_q;
    assign finish   = (state_q == ST_FIN);

    assign img_addr = pix_cnt_q[IMG_AW-1:0];
    assign cm.din   = din_ok_q ? img_rdata : '0;

    assign res_we    = res_we_q;
    assign res_addr  = res_addr_q;
    assign res_wdata = res_wdata_q;
    assign res_count = res_count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed bench for conv_stream_ctrl: a cycle-level behavioural model is compared
// against every output each cycle, plus literal spot checks per scenario.
module tb_conv_stream_ctrl;
    import bnn_pkg::*;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              go = 1'b0;
    logic              mode = 1'b0;
    logic [W_AW-1:0]   w_addr;
    logic [DATA_W-1:0] w_rdata;
    logic [IMG_AW-1:0] img_addr;
    logic [DATA_W-1:0] img_rdata;
    logic              res_we;
    logic [RES_AW-1:0] res_addr;
    logic [DATA_W-1:0] res_wdata;
    logic              busy;
    logic              finish;
    logic [RES_AW:0]   res_count;
    logic              err;

    conv_stream_ctrl_if cm ();

    always #5 clk = ~clk;

    conv_stream_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .go        (go),
        .mode      (mode),
        .w_addr    (w_addr),
        .w_rdata   (w_rdata),
        .img_addr  (img_addr),
        .img_rdata (img_rdata),
        .cm        (cm),
        .res_we    (res_we),
        .res_addr  (res_addr),
        .res_wdata (res_wdata),
        .busy      (busy),
        .finish    (finish),
        .res_count (res_count),
        .err       (err)
    );

    // Synchronous-read RAMs around the controller.
    logic [DATA_W-1:0] wmem    [32];
    logic [DATA_W-1:0] img_mem [1024];
    logic [DATA_W-1:0] rmem    [1024];
    logic [DATA_W-1:0] din_seen [800];

    always @(posedge clk) begin
        w_rdata   <= wmem[w_addr];
        img_rdata <= img_mem[img_addr];
        if (res_we) rmem[res_addr] <= res_wdata;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] res_pat(input int k);
        return 32'h8000_0000 | 32'(k * 7);
    endfunction

    // Behavioural model: phase of the run plus the counts the rules talk about.
    typedef enum {M_IDLE, M_PRE, M_LOAD, M_RUN, M_FIN} mph_e;
    mph_e        m_ph = M_IDLE;
    int          m_lcnt = 0, m_acc = 0, m_cnt = 0, m_waddr = 0;
    bit          m_mode = 0, m_we = 0, m_err = 0;
    logic [31:0] m_din = '0, m_wdata = '0;

    always @(negedge clk) begin
        logic e_run, e_wbit;
        int   e_waddr;
        if (chk_en) begin
            e_run   = (m_ph == M_PRE) || (m_ph == M_LOAD) || (m_ph == M_RUN);
            e_waddr = (m_ph == M_LOAD) ? m_lcnt + 1 : 0;
            e_wbit  = (m_ph == M_LOAD) ? !wmem[m_lcnt][31] : 1'b0;
            check("busy",      busy,         e_run);
            check("cm_start",  cm.start,     e_run);
            check("cm_state",  cm.state,     m_mode);
            check("weight_en", cm.weight_en, m_ph == M_LOAD);
            check("weight",    cm.weight,    e_wbit);
            check("w_addr",    w_addr,       e_waddr);
            check("img_addr",  img_addr,     m_acc);
            check("cm_din",    cm.din,       m_din);
            check("res_we",    res_we,       m_we);
            if (m_we) begin
                check("res_addr",  res_addr,  m_waddr);
                check("res_wdata", res_wdata, m_wdata);
            end
            check("res_count", res_count, m_cnt);
            check("err",       err,       m_err);
            check("finish",    finish,    m_ph == M_FIN);
        end

        m_we  = 1'b0;
        m_din = '0;
        if (!rstn) begin
            m_ph = M_IDLE; m_lcnt = 0; m_acc = 0; m_cnt = 0; m_mode = 0; m_err = 0;
        end else begin
            case (m_ph)
                M_IDLE: if (go) begin
                    m_ph = M_PRE; m_mode = mode; m_acc = 0; m_cnt = 0; m_err = 0;
                end
                M_PRE: begin m_ph = M_LOAD; m_lcnt = 0; end
                M_LOAD: if (m_lcnt == W_CNT - 1) m_ph = M_RUN; else m_lcnt++;
                M_RUN: begin
                    if (m_acc < IMG_PIX) m_din = img_mem[m_acc];
                    if (cm.din_ready && m_acc < IMG_PIX) m_acc++;
                    if (cm.ovalid || cm.done) begin
                        if (m_cnt < (1 << RES_AW)) begin
                            m_we = 1'b1; m_waddr = m_cnt; m_wdata = cm.dout; m_cnt++;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                    if (cm.done) begin
                        m_ph = M_FIN;
                        if (m_cnt != (m_mode ? N_OUT1 : N_OUT0)) m_err = 1'b1;
                    end
                end
                default: m_ph = M_IDLE;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse go and walk through W_PRE and W_LOAD; returns in the first RUN cycle.
    task automatic do_go(input bit md, input bit done_in_load,
                         output int en_cycles, output logic [31:0] wbits);
        go = 1'b1; mode = md;
        step();
        go = 1'b0;
        check("pre_w_addr", w_addr, 0);
        check("pre_start",  cm.start, 1);
        en_cycles = 0;
        wbits = '0;
        for (int k = 0; k < W_CNT + 1; k++) begin
            cm.done = done_in_load && (k == 10);
            step();
            if (cm.weight_en) begin
                if (en_cycles < 32) wbits[en_cycles] = cm.weight;
                en_cycles++;
            end
        end
        cm.done = 1'b0;
    endtask

    // Stream pixels with din_ready held high, emit results, then end with done; returns in FIN.
    task automatic run_phase(input int cycles, input int period, input int n_ov,
                             input bit end_ovalid, input int go_at);
        int nres = 0;
        for (int t = 0; t < cycles; t++) begin
            cm.din_ready = 1'b1;
            cm.ovalid    = (t % period == period - 1) && (nres < n_ov);
            cm.dout      = res_pat(nres);
            go           = (t == go_at);
            if (cm.ovalid) nres++;
            step();
            if (t < 800) din_seen[t] = cm.din;
            if (t == go_at) begin
                check("go_ignored_w_addr", w_addr, 0);
                check("go_ignored_busy",   busy,   1);
            end
        end
        go = 1'b0;
        cm.din_ready = 1'b0;
        cm.done      = 1'b1;
        cm.ovalid    = end_ovalid;
        cm.dout      = res_pat(nres);
        step();
        cm.done   = 1'b0;
        cm.ovalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          en;
        logic [31:0] wb;
        for (int i = 0; i < 32; i++) wmem[i] = {i[0], 31'(i * 3 + 5)};
        for (int i = 0; i < 1024; i++) begin
            img_mem[i] = 32'(i);
            rmem[i]    = '0;
        end
        cm.din_ready = 1'b0; cm.ovalid = 1'b0; cm.done = 1'b0; cm.dout = '0;

        step();
        chk_en = 1'b1;
        step();
        check("rst_busy",      busy,      0);
        check("rst_res_count", res_count, 0);
        rstn = 1'b1;
        step();

        // Weight load, full pixel stream, 144-result mode-0 run.
        do_go(1'b0, 1'b0, en, wb);
        check("w_en_cycles", en, 25);
        check("w_bits",      wb, 32'h0155_5555);
        run_phase(800, 5, 143, 1'b1, -1);
        check("a_finish",    finish,    1);
        check("a_res_count", res_count, 144);
        check("a_err",       err,       0);
        check("a_last_addr", res_addr,  143);
        step();
        check("a_finish_low", finish, 0);
        check("a_rmem0",   rmem[0],   32'h8000_0000);
        check("a_rmem72",  rmem[72],  32'h8000_01F8);
        check("a_rmem143", rmem[143], 32'h8000_03E9);
        check("a_din0",   din_seen[0],   0);
        check("a_din500", din_seen[500], 500);
        check("a_din783", din_seen[783], 783);
        check("a_din784", din_seen[784], 0);
        check("a_din799", din_seen[799], 0);

        // Mode 1 with 20 results: done during load and go during run are ignored.
        step();
        do_go(1'b1, 1'b1, en, wb);
        run_phase(100, 5, 19, 1'b1, 50);
        check("b_res_count", res_count, 20);
        check("b_err",       err,       1);
        step();
        check("b_err_sticky", err, 1);

        // Next go clears err; run ends with done alone giving exactly 16 results.
        step();
        do_go(1'b1, 1'b0, en, wb);
        check("c_err_cleared", err, 0);
        run_phase(60, 4, 15, 1'b0, -1);
        check("c_res_count", res_count, 16);
        check("c_err",       err,       0);
        check("c_done_we",   res_we,    1);
        step();

        // Reset in the middle of the pixel stream.
        step();
        do_go(1'b0, 1'b0, en, wb);
        for (int t = 0; t < 300; t++) begin
            cm.din_ready = 1'b1;
            step();
        end
        check("d_img_addr_300", img_addr, 300);
        rstn = 1'b0; cm.ovalid = 1'b1;
        step();
        check("d_rst_we",       res_we,       0);
        check("d_rst_busy",     busy,         0);
        check("d_rst_start",    cm.start,     0);
        check("d_rst_img_addr", img_addr,     0);
        check("d_rst_din",      cm.din,       0);
        check("d_rst_count",    res_count,    0);
        check("d_rst_state",    cm.state,     0);
        check("d_rst_wen",      cm.weight_en, 0);
        rstn = 1'b1; cm.ovalid = 1'b0; cm.din_ready = 1'b0;
        step();
        check("d_post_rst_we", res_we, 0);

        // Fresh run restarts the image at address 0; one result in mode 0 is a mismatch.
        do_go(1'b0, 1'b0, en, wb);
        check("e_img_addr0", img_addr, 0);
        run_phase(10, 3, 0, 1'b0, -1);
        check("e_res_count", res_count, 1);
        check("e_err",       err,       1);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
